// File: rtl/uart_cfg_xcvr_if.sv
// Fabric-side handshake bundle for the configurable UART transceiver.
// The master is the fabric logic; the slave is the transceiver itself.
interface uart_cfg_xcvr_if #(
    parameter int DATA_BITS = 8
);
    logic                 tx_start;
    logic [DATA_BITS-1:0] tx_data;
    logic                 tx_busy;
    logic [DATA_BITS-1:0] rx_data;
    logic                 rx_valid;
    logic                 rx_parity_err;
    logic                 rx_frame_err;

    modport master (
        output tx_start, tx_data,
        input  tx_busy, rx_data, rx_valid, rx_parity_err, rx_frame_err
    );

    modport slave (
        input  tx_start, tx_data,
        output tx_busy, rx_data, rx_valid, rx_parity_err, rx_frame_err
    );
endinterface

// File: rtl/uart_cfg_xcvr.sv
// Full-duplex UART with configurable data width, parity and stop bits.
// TX and RX are independent FSMs; RX has a 2-flop synchroniser,
// false-start rejection, parity/framing checks and break handling.
module uart_cfg_xcvr #(
    parameter int CLOCK_FREQ = 10_000_000,
    parameter int BAUD       = 115200,
    parameter int DATA_BITS  = 8,
    parameter int PARITY     = 0,
    parameter int STOP_BITS  = 1
) (
    input  logic           clk,
    input  logic           rst,
    uart_cfg_xcvr_if.slave bus,
    output logic           tx,
    input  logic           rx
);
    localparam int BIT_CLKS = CLOCK_FREQ / BAUD;
    localparam int CW       = $clog2(BIT_CLKS * STOP_BITS + 1);
    localparam int BW       = $clog2(DATA_BITS + 1);

    localparam logic [CW-1:0] BIT_LAST  = CW'(BIT_CLKS - 1);
    localparam logic [CW-1:0] HALF_LAST = CW'(BIT_CLKS / 2 - 1);
    localparam logic [CW-1:0] STOP_LAST = CW'(BIT_CLKS * STOP_BITS - 1);
    localparam logic [BW-1:0] DATA_LAST = BW'(DATA_BITS - 1);
    localparam logic [BW-1:0] SIDX_LAST = BW'(STOP_BITS - 1);

    // Parity bit that belongs with a payload: odd -> ~^d, even -> ^d.
    function automatic logic par_of(input logic [DATA_BITS-1:0] d);
        return (PARITY == 1) ? ~^d : ^d;
    endfunction

    // ------------------------------------------------------------------
    // Transmitter
    // ------------------------------------------------------------------
    typedef enum logic [2:0] {
        TX_IDLE, TX_START, TX_DATA, TX_PAR, TX_STOP
    } tx_state_t;

    tx_state_t            tx_state_q;
    logic                 tx_q;
    logic                 tx_busy_q;
    logic [CW-1:0]        tx_cnt_q;
    logic [BW-1:0]        tx_bit_q;
    logic [DATA_BITS-1:0] tx_sh_q;
    logic                 tx_par_q;

    // TX frame sequencer; tx and tx_busy are registered FSM outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            tx_state_q <= TX_IDLE;
            tx_q       <= 1'b1;
            tx_busy_q  <= 1'b0;
            tx_cnt_q   <= '0;
            tx_bit_q   <= '0;
            tx_sh_q    <= '0;
            tx_par_q   <= 1'b0;
        end else begin
            case (tx_state_q)
                TX_IDLE: begin
                    if (bus.tx_start) begin
                        tx_sh_q    <= bus.tx_data;
                        tx_par_q   <= par_of(bus.tx_data);
                        tx_q       <= 1'b0;
                        tx_busy_q  <= 1'b1;
                        tx_cnt_q   <= '0;
                        tx_state_q <= TX_START;
                    end
                end
                TX_START: begin
                    if (tx_cnt_q == BIT_LAST) begin
                        tx_cnt_q   <= '0;
                        tx_bit_q   <= '0;
                        tx_q       <= tx_sh_q[0];
                        tx_sh_q    <= tx_sh_q >> 1;
                        tx_state_q <= TX_DATA;
                    end else begin
                        tx_cnt_q <= tx_cnt_q + 1'b1;
                    end
                end
                TX_DATA: begin
                    if (tx_cnt_q == BIT_LAST) begin
                        tx_cnt_q <= '0;
                        if (tx_bit_q == DATA_LAST) begin
                            if (PARITY != 0) begin
                                tx_q       <= tx_par_q;
                                tx_state_q <= TX_PAR;
                            end else begin
                                tx_q       <= 1'b1;
                                tx_state_q <= TX_STOP;
                            end
                        end else begin
                            tx_bit_q <= tx_bit_q + 1'b1;
                            tx_q     <= tx_sh_q[0];
                            tx_sh_q  <= tx_sh_q >> 1;
                        end
                    end else begin
                        tx_cnt_q <= tx_cnt_q + 1'b1;
                    end
                end
                TX_PAR: begin
                    if (tx_cnt_q == BIT_LAST) begin
                        tx_cnt_q   <= '0;
                        tx_q       <= 1'b1;
                        tx_state_q <= TX_STOP;
                    end else begin
                        tx_cnt_q <= tx_cnt_q + 1'b1;
                    end
                end
                TX_STOP: begin
                    // All stop bits are one continuous high period.
                    if (tx_cnt_q == STOP_LAST) begin
                        tx_cnt_q   <= '0;
                        tx_busy_q  <= 1'b0;
                        tx_state_q <= TX_IDLE;
                    end else begin
                        tx_cnt_q <= tx_cnt_q + 1'b1;
                    end
                end
                default: tx_state_q <= TX_IDLE;
            endcase
        end
    end

    assign tx          = tx_q;
    assign bus.tx_busy = tx_busy_q;

    // ------------------------------------------------------------------
    // Receiver
    // ------------------------------------------------------------------
    logic rx_s1_q;
    logic rx_s2_q;
    logic rx_s;

    // Two-flop synchroniser for the asynchronous line; idles high.
    always_ff @(posedge clk) begin
        if (rst) begin
            rx_s1_q <= 1'b1;
            rx_s2_q <= 1'b1;
        end else begin
            rx_s1_q <= rx;
            rx_s2_q <= rx_s1_q;
        end
    end

    assign rx_s = rx_s2_q;

    typedef enum logic [2:0] {
        RX_IDLE, RX_START, RX_DATA, RX_PAR, RX_STOP, RX_BREAK
    } rx_state_t;

    rx_state_t            rx_state_q;
    logic                 rx_prev_q;
    logic [CW-1:0]        rx_cnt_q;
    logic [BW-1:0]        rx_bit_q;
    logic [DATA_BITS-1:0] rx_sh_q;
    logic                 rx_par_bit_q;
    logic                 rx_ferr_acc_q;
    logic [DATA_BITS-1:0] rx_data_q;
    logic                 rx_valid_q;
    logic                 rx_perr_q;
    logic                 rx_ferr_q;

    // RX frame sequencer: mid-bit sampling, result registers and strobe.
    always_ff @(posedge clk) begin
        if (rst) begin
            rx_state_q    <= RX_IDLE;
            rx_prev_q     <= 1'b1;
            rx_cnt_q      <= '0;
            rx_bit_q      <= '0;
            rx_sh_q       <= '0;
            rx_par_bit_q  <= 1'b0;
            rx_ferr_acc_q <= 1'b0;
            rx_data_q     <= '0;
            rx_valid_q    <= 1'b0;
            rx_perr_q     <= 1'b0;
            rx_ferr_q     <= 1'b0;
        end else begin
            rx_valid_q <= 1'b0;
            rx_prev_q  <= rx_s;
            case (rx_state_q)
                RX_IDLE: begin
                    if (rx_prev_q && !rx_s) begin
                        rx_cnt_q   <= '0;
                        rx_state_q <= RX_START;
                    end
                end
                RX_START: begin
                    if (rx_cnt_q == HALF_LAST) begin
                        rx_cnt_q <= '0;
                        rx_bit_q <= '0;
                        // A line back high at mid start bit was a glitch.
                        rx_state_q <= rx_s ? RX_IDLE : RX_DATA;
                    end else begin
                        rx_cnt_q <= rx_cnt_q + 1'b1;
                    end
                end
                RX_DATA: begin
                    if (rx_cnt_q == BIT_LAST) begin
                        rx_cnt_q <= '0;
                        rx_sh_q  <= {rx_s, rx_sh_q[DATA_BITS-1:1]};
                        if (rx_bit_q == DATA_LAST) begin
                            rx_bit_q      <= '0;
                            rx_ferr_acc_q <= 1'b0;
                            rx_state_q    <= (PARITY != 0) ? RX_PAR : RX_STOP;
                        end else begin
                            rx_bit_q <= rx_bit_q + 1'b1;
                        end
                    end else begin
                        rx_cnt_q <= rx_cnt_q + 1'b1;
                    end
                end
                RX_PAR: begin
                    if (rx_cnt_q == BIT_LAST) begin
                        rx_cnt_q      <= '0;
                        rx_par_bit_q  <= rx_s;
                        rx_bit_q      <= '0;
                        rx_ferr_acc_q <= 1'b0;
                        rx_state_q    <= RX_STOP;
                    end else begin
                        rx_cnt_q <= rx_cnt_q + 1'b1;
                    end
                end
                RX_STOP: begin
                    if (rx_cnt_q == BIT_LAST) begin
                        rx_cnt_q <= '0;
                        if (rx_bit_q == SIDX_LAST) begin
                            rx_valid_q <= 1'b1;
                            rx_data_q  <= rx_sh_q;
                            rx_perr_q  <= (PARITY != 0) &&
                                          (rx_par_bit_q != par_of(rx_sh_q));
                            rx_ferr_q  <= rx_ferr_acc_q | ~rx_s;
                            // A line still low here is a break: one strobe only.
                            rx_state_q <= rx_s ? RX_IDLE : RX_BREAK;
                        end else begin
                            rx_bit_q      <= rx_bit_q + 1'b1;
                            rx_ferr_acc_q <= rx_ferr_acc_q | ~rx_s;
                        end
                    end else begin
                        rx_cnt_q <= rx_cnt_q + 1'b1;
                    end
                end
                RX_BREAK: begin
                    if (rx_s) begin
                        rx_state_q <= RX_IDLE;
                    end
                end
                default: rx_state_q <= RX_IDLE;
            endcase
        end
    end

    assign bus.rx_data       = rx_data_q;
    assign bus.rx_valid      = rx_valid_q;
    assign bus.rx_parity_err = rx_perr_q;
    assign bus.rx_frame_err  = rx_ferr_q;
endmodule

// File: tb/tb_uart_cfg_xcvr.sv
// Directed bench: an 8N1 default instance (u0) and a 7E2 instance (u1),
// each looped back from tx to rx with bench-controlled line overrides.
module tb_uart_cfg_xcvr;
    logic clk;
    logic rst;
    logic tx0, rx0, tx1, rx1;
    logic loop0, rx0_drv, flip1;

    int checks = 0;
    int errors = 0;

    uart_cfg_xcvr_if #(.DATA_BITS(8)) bus0 ();
    uart_cfg_xcvr_if #(.DATA_BITS(7)) bus1 ();

    uart_cfg_xcvr u0 (
        .clk (clk),
        .rst (rst),
        .bus (bus0),
        .tx  (tx0),
        .rx  (rx0)
    );

    uart_cfg_xcvr #(
        .DATA_BITS (7),
        .PARITY    (2),
        .STOP_BITS (2)
    ) u1 (
        .clk (clk),
        .rst (rst),
        .bus (bus1),
        .tx  (tx1),
        .rx  (rx1)
    );

    assign rx0 = loop0 ? tx0 : rx0_drv;
    assign rx1 = tx1 ^ flip1;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Receive log: {parity_err, frame_err, data} per strobe.
    logic [9:0] q0[$];
    logic [8:0] q1[$];

    always @(negedge clk) begin
        if (bus0.rx_valid === 1'b1) begin
            q0.push_back({bus0.rx_parity_err, bus0.rx_frame_err, bus0.rx_data});
            $display("[%0t] u0 rx data=%h perr=%b ferr=%b", $time,
                     bus0.rx_data, bus0.rx_parity_err, bus0.rx_frame_err);
        end
        if (bus1.rx_valid === 1'b1) begin
            q1.push_back({bus1.rx_parity_err, bus1.rx_frame_err, bus1.rx_data});
            $display("[%0t] u1 rx data=%h perr=%b ferr=%b", $time,
                     bus1.rx_data, bus1.rx_parity_err, bus1.rx_frame_err);
        end
    end

    task automatic wait_q0(input int n, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            if (q0.size() >= n) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic wait_q1(input int n, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            if (q1.size() >= n) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    // Returns at the first negedge with tx_busy high (frame cycle 0).
    task automatic send0(input logic [7:0] d);
        for (int i = 0; i < 2000; i++) begin
            if (bus0.tx_busy === 1'b0) break;
            @(negedge clk);
        end
        bus0.tx_start = 1'b1;
        bus0.tx_data  = d;
        @(negedge clk);
        bus0.tx_start = 1'b0;
        $display("[%0t] u0 tx data=%h", $time, d);
    endtask

    task automatic send1(input logic [6:0] d);
        for (int i = 0; i < 2000; i++) begin
            if (bus1.tx_busy === 1'b0) break;
            @(negedge clk);
        end
        bus1.tx_start = 1'b1;
        bus1.tx_data  = d;
        @(negedge clk);
        bus1.tx_start = 1'b0;
        $display("[%0t] u1 tx data=%h", $time, d);
    endtask

    // Runs one 7E2 frame to its end; optionally inverts the parity bit
    // (frame cycles 688..773) on the way to rx, and samples it mid-bit.
    task automatic run_frame1(input bit inv, output int c, output logic pbit);
        c    = 0;
        pbit = 1'bx;
        while (bus1.tx_busy === 1'b1 && c < 5000) begin
            if (inv && c == 688) flip1 = 1'b1;
            if (c == 731) pbit = tx1;
            if (c == 774) flip1 = 1'b0;
            c++;
            @(negedge clk);
        end
        flip1 = 1'b0;
    endtask

    task automatic test_reset;
        rst = 1'b1;
        repeat (3) @(negedge clk);
        checks++; if (tx0 !== 1'b1) begin errors++; $display("FAIL reset_tx0 got %b exp 1", tx0); end
        checks++; if (bus0.tx_busy !== 1'b0) begin errors++; $display("FAIL reset_busy0 got %b exp 0", bus0.tx_busy); end
        checks++; if (bus0.rx_valid !== 1'b0) begin errors++; $display("FAIL reset_valid0 got %b exp 0", bus0.rx_valid); end
        checks++; if (bus0.rx_data !== 8'h00) begin errors++; $display("FAIL reset_data0 got %h exp 00", bus0.rx_data); end
        checks++; if ({bus0.rx_parity_err, bus0.rx_frame_err} !== 2'b00) begin
            errors++; $display("FAIL reset_flags0 got %b%b exp 00", bus0.rx_parity_err, bus0.rx_frame_err); end
        checks++; if (tx1 !== 1'b1) begin errors++; $display("FAIL reset_tx1 got %b exp 1", tx1); end
        checks++; if (bus1.tx_busy !== 1'b0) begin errors++; $display("FAIL reset_busy1 got %b exp 0", bus1.tx_busy); end
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_default_loopback;
        int n = q0.size();
        int c = 0;
        bit ok;
        logic [9:0] expf = {1'b1, 8'h55, 1'b0};
        send0(8'h55);
        while (bus0.tx_busy === 1'b1 && c < 5000) begin
            if ((c % 86) == 43 && (c / 86) < 10) begin
                checks++;
                if (tx0 !== expf[c / 86]) begin
                    errors++; $display("FAIL tx_bit%0d got %b exp %b", c / 86, tx0, expf[c / 86]);
                end
            end
            c++;
            @(negedge clk);
        end
        checks++; if (c != 860) begin errors++; $display("FAIL busy_len_8n1 got %0d exp 860", c); end
        wait_q0(n + 1, ok);
        checks++;
        if (!ok) begin errors++; $display("FAIL rx_55 timeout"); end
        else if (q0[n] !== {2'b00, 8'h55}) begin errors++; $display("FAIL rx_55 got %h exp 055", q0[n]); end
    endtask

    task automatic test_cfg_parity;
        int n = q1.size();
        int c;
        logic pb;
        bit ok;
        send1(7'h41);
        run_frame1(1'b0, c, pb);
        checks++; if (pb !== 1'b0) begin errors++; $display("FAIL par_bit_wire got %b exp 0", pb); end
        checks++; if (c != 946) begin errors++; $display("FAIL busy_len_7e2 got %0d exp 946", c); end
        wait_q1(n + 1, ok);
        checks++;
        if (!ok) begin errors++; $display("FAIL rx_41 timeout"); end
        else if (q1[n] !== {2'b00, 7'h41}) begin errors++; $display("FAIL rx_41 got %h exp 041", q1[n]); end
    endtask

    task automatic test_parity_error;
        int n = q1.size();
        int c;
        logic pb;
        bit ok;
        send1(7'h41);
        run_frame1(1'b1, c, pb);
        wait_q1(n + 1, ok);
        checks++;
        if (!ok) begin errors++; $display("FAIL rx_perr timeout"); end
        else if (q1[n] !== {1'b1, 1'b0, 7'h41}) begin errors++; $display("FAIL rx_perr got %h exp 141", q1[n]); end
    endtask

    task automatic test_break;
        int n = q0.size();
        bit ok;
        loop0   = 1'b0;
        rx0_drv = 1'b0;
        repeat (2900) @(negedge clk);
        checks++;
        if (q0.size() != n + 1) begin errors++; $display("FAIL break_count got %0d exp 1", q0.size() - n); end
        checks++;
        if (q0.size() <= n) begin errors++; $display("FAIL break_flags no strobe"); end
        else if (q0[n] !== {1'b0, 1'b1, 8'h00}) begin errors++; $display("FAIL break_flags got %h exp 100", q0[n]); end
        rx0_drv = 1'b1;
        repeat (1000) @(negedge clk);
        checks++;
        if (q0.size() != n + 1) begin errors++; $display("FAIL break_release got %0d strobes exp 1", q0.size() - n); end
        loop0 = 1'b1;
        send0(8'hC3);
        wait_q0(n + 2, ok);
        checks++;
        if (!ok) begin errors++; $display("FAIL rx_c3 timeout"); end
        else if (q0[n + 1] !== {2'b00, 8'hC3}) begin errors++; $display("FAIL rx_c3 got %h exp 0c3", q0[n + 1]); end
    endtask

    task automatic test_back_to_back;
        int n = q0.size();
        int c = 0;
        bit ok;
        loop0   = 1'b0;
        rx0_drv = 1'b0;
        repeat (20) @(negedge clk);
        rx0_drv = 1'b1;
        repeat (300) @(negedge clk);
        checks++;
        if (q0.size() != n) begin errors++; $display("FAIL glitch got %0d strobes exp 0", q0.size() - n); end
        loop0 = 1'b1;
        send0(8'hA5);
        while (bus0.tx_busy === 1'b1 && c < 5000) begin
            if (c == 300) begin bus0.tx_start = 1'b1; bus0.tx_data = 8'hFF; end
            if (c == 301) bus0.tx_start = 1'b0;
            c++;
            @(negedge clk);
        end
        checks++; if (c != 860) begin errors++; $display("FAIL busy_len_ignored_start got %0d exp 860", c); end
        bus0.tx_start = 1'b1;
        bus0.tx_data  = 8'h3C;
        @(negedge clk);
        bus0.tx_start = 1'b0;
        $display("[%0t] u0 tx data=3c", $time);
        checks++;
        if ({bus0.tx_busy, tx0} !== 2'b10) begin
            errors++; $display("FAIL b2b_restart got busy=%b tx=%b exp busy=1 tx=0", bus0.tx_busy, tx0);
        end
        wait_q0(n + 2, ok);
        checks++;
        if (!ok) begin errors++; $display("FAIL b2b_rx timeout"); end
        else if (q0[n] !== {2'b00, 8'hA5} || q0[n + 1] !== {2'b00, 8'h3C}) begin
            errors++; $display("FAIL b2b_rx got %h %h exp 0a5 03c", q0[n], q0[n + 1]);
        end
    endtask

    task automatic test_reset_midframe;
        int n;
        bit ok;
        send0(8'hFF);
        n = q0.size();
        repeat (5 * 86 + 40) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        checks++;
        if ({tx0, bus0.tx_busy} !== 2'b10) begin
            errors++; $display("FAIL midreset got tx=%b busy=%b exp tx=1 busy=0", tx0, bus0.tx_busy);
        end
        rst = 1'b0;
        repeat (1200) @(negedge clk);
        checks++;
        if (q0.size() != n) begin errors++; $display("FAIL midreset_strobe got %0d exp 0", q0.size() - n); end
        send0(8'h12);
        wait_q0(n + 1, ok);
        checks++;
        if (!ok) begin errors++; $display("FAIL rx_12 timeout"); end
        else if (q0[n] !== {2'b00, 8'h12}) begin errors++; $display("FAIL rx_12 got %h exp 012", q0[n]); end
    endtask

    initial begin
        rst           = 1'b1;
        loop0         = 1'b1;
        rx0_drv       = 1'b1;
        flip1         = 1'b0;
        bus0.tx_start = 1'b0;
        bus0.tx_data  = '0;
        bus1.tx_start = 1'b0;
        bus1.tx_data  = '0;
        @(negedge clk);
        test_reset;
        test_default_loopback;
        test_cfg_parity;
        test_parity_error;
        test_break;
        test_back_to_back;
        test_reset_midframe;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog simulation did not complete");
        $fatal(1, "watchdog");
    end
endmodule
